mp3_interval_timer: RTL and testbench
=====================================

// Module: mp3_interval_timer
// PURPOSE
//  Avalon-MM interval timer: parametrised counter width, software-writable period, clock prescaler,
//  one-shot/continuous modes, snapshot and missed-timeout count. Sits on the system bus beside the
//  CPU. Provides the playback tick and the UI tick from one generic block instead of fixed-period timers.
// PARAMETERS
//  COUNTER_W    32            counter/period width, 2..32; period_h holds bits COUNTER_W-1:16
//  RESET_PERIOD 32'h02FAF07F  period and counter value at reset (1 s at 50 MHz), truncated to COUNTER_W
//  PRESCALE_W   8             prescaler width; tick every PRESCALE+1 clk
// PORTS
//  clk            in   1   clock
//  reset_n        in   1   reset; asynchronous, active-low
//  address        in   3   word address, register map below
//  chipselect     in   1   slave select
//  write_n        in   1   active-low write
//  writedata      in   16  write data
//  readdata       out  16  read data, registered, 1-cycle latency
//  irq            out  1   TO && ITO, level
//  timeout_pulse  out  1   present only with MP3_TIMER_PULSE_OUT_EN
// BEHAVIOUR
//  Map: 0 STATUS {RUN[1] RO, TO[0]; any write clears TO and MISSED}; 1 CONTROL {STOP[3] WO, START[2] WO,
//   CONT[1], ITO[0]}, reads {0,0,CONT,ITO}; 2/3 PERIOD_L/H; 4/5 SNAP_L/H (write captures, read returns);
//   6 PRESCALE[PRESCALE_W-1:0]; 7 MISSED[7:0] RO. Unused/out-of-width bits read 0, ignored on write.
//  Write = chipselect && !write_n. readdata updated every clk from the mux of address (no chipselect gate).
//  Reset: counter=period=RESET_PERIOD, prescaler cnt=0, PRESCALE=0, RUN=TO=CONT=ITO=0, MISSED=0,
//   snapshot=0, readdata=0, irq=0, timeout_pulse=0.
//  Tick: prescaler cnt increments while RUN; tick when cnt==PRESCALE, then cnt<=0. PRESCALE=0 -> every clk.
//   cnt cleared on START and on force_reload.
//  Count: on tick, counter!=0 -> counter-1; counter==0 -> timeout event, counter<=period.
//   Interval = (period+1)*(PRESCALE+1) clk. Event fires exactly once per zero (no level re-trigger).
//  Event: TO<=1; if TO already 1 and no STATUS write this cycle, MISSED+=1 saturating at 255;
//   if !CONT, RUN<=0 at the same edge (counter holds reloaded period).
//  STATUS write coincident with event: event wins, TO stays 1, MISSED cleared to 0.
//  PERIOD_L/H write: half updated at the edge; force_reload next cycle: counter<=period, cnt<=0, RUN<=0.
//  RUN priority: START > (STOP | force_reload | one-shot event). START while running restarts prescaler
//   only; counter continues from its current value.
//  SNAP write: snapshot<=counter value before that edge's update. Reading never side-effects.
//  Reset mid-count: all state returns to reset values asynchronously; no event is generated.
// CONFIGURATION
//  MP3_TIMER_PULSE_OUT_EN defined: timeout_pulse port exists, high exactly 1 clk per timeout event
//   (same edge TO sets), independent of ITO/TO. Undefined: port and logic absent; all else identical.
// STRUCTURE
//  Package mp3_timer_pkg: register address localparams (ADDR_STATUS..ADDR_MISSED), CONTROL/STATUS
//   bit indices, MISSED_MAX=255.
//  Sub-module mp3_timer_prescaler (enable, clear, prescale in; tick out); counter, registers,
//   bus mux in top.
// TESTING
//  Reset, read addr 1..7 -> 0 except PERIOD_L=16'hF07F, PERIOD_H=16'h02FA; irq=0, RUN=0.
//  PERIOD=4, PRESCALE=0, CONTROL=4'h7 -> TO sets every 5 clk, irq high after 1st; STATUS write clears.
//  PERIOD=9, PRESCALE=3, CONTROL=4'h4 (one-shot) -> one event at 40 clk, RUN=0, counter=9, no 2nd event.
//  Continuous PERIOD=2, never clear TO for 300 periods -> MISSED reads 255 (saturated); STATUS write -> 0.
//  STATUS write on event clk -> TO=1, MISSED=0; START+STOP one write -> RUN=1; PERIOD write running -> RUN=0.
//  SNAP_L write at known count -> SNAP_L/H return pre-edge value; with macro, pulse count == event count.

Source files
------------

// File: rtl/mp3_timer_pkg.sv
// mp3 interval timer: shared register map and bit positions.
// Imported by mp3_interval_timer and mp3_timer_prescaler.
package mp3_timer_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;
  localparam logic [2:0] ADDR_PRESCALE = 3'd6;
  localparam logic [2:0] ADDR_MISSED   = 3'd7;

  localparam int ST_TO     = 0;
  localparam int ST_RUN    = 1;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam logic [7:0] MISSED_MAX = 8'd255;

endpackage

// File: rtl/mp3_timer_prescaler.sv
// Clock prescaler: tick once every prescale+1 enabled clocks.
// Ports: clk, reset_n, enable, clear, prescale in; tick out.
module mp3_timer_prescaler
  import mp3_timer_pkg::*;
#(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_q;
  logic [PRESCALE_W-1:0] cnt_d;

  // A clear (start/reload) takes precedence over the tick.
  assign tick = enable && !clear && (cnt_q == prescale);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mp3_interval_timer.sv
// Avalon-MM interval timer with prescaler, one-shot/continuous modes,
// snapshot and missed-timeout count. Ports: clk, reset_n, address,
// chipselect, write_n, writedata, readdata, irq; timeout_pulse only
// when MP3_TIMER_PULSE_OUT_EN is defined.
module mp3_interval_timer
  import mp3_timer_pkg::*;
#(
  parameter int          COUNTER_W    = 32,
  parameter logic [31:0] RESET_PERIOD = 32'h02FAF07F,
  parameter int          PRESCALE_W   = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
`ifdef MP3_TIMER_PULSE_OUT_EN
  ,
  output logic        timeout_pulse
`endif
);

  localparam logic [COUNTER_W-1:0] RST_P =
    RESET_PERIOD[COUNTER_W-1:0];

  logic [COUNTER_W-1:0]  counter_q, counter_d;
  logic [COUNTER_W-1:0]  period_q, period_d;
  logic [COUNTER_W-1:0]  snap_q, snap_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [7:0]            missed_q, missed_d;
  logic                  run_q, run_d;
  logic                  to_q, to_d;
  logic                  cont_q, cont_d;
  logic                  ito_q, ito_d;
  logic                  reload_q, reload_d;
  logic [15:0]           rd_q, rd_d;
  logic                  irq_q, irq_d;

  logic wr;
  logic wr_status, wr_ctrl, wr_pl, wr_ph;
  logic wr_snap, wr_psc;
  logic start, stop;
  logic tick, evt;

  logic [31:0] per_wr;
  logic [31:0] per_rd;
  logic [31:0] snap_rd;
  logic [31:0] psc_rd;

  assign wr        = chipselect && !write_n;
  assign wr_status = wr && (address == ADDR_STATUS);
  assign wr_ctrl   = wr && (address == ADDR_CONTROL);
  assign wr_pl     = wr && (address == ADDR_PERIOD_L);
  assign wr_ph     = wr && (address == ADDR_PERIOD_H);
  assign wr_snap   = wr && ((address == ADDR_SNAP_L) ||
                            (address == ADDR_SNAP_H));
  assign wr_psc    = wr && (address == ADDR_PRESCALE);
  assign start     = wr_ctrl && writedata[CTL_START];
  assign stop      = wr_ctrl && writedata[CTL_STOP];

  mp3_timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (run_q),
    .clear    (start || reload_q),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // One event per zero: the same tick reloads the counter.
  assign evt = tick && (counter_q == '0);

  always_comb begin
    per_wr = 32'(period_q);
    if (wr_pl) per_wr[15:0]  = writedata;
    if (wr_ph) per_wr[31:16] = writedata;
    period_d = per_wr[COUNTER_W-1:0];
    reload_d = wr_pl || wr_ph;

    counter_d = counter_q;
    if (reload_q) begin
      counter_d = period_q;
    end else if (tick) begin
      counter_d = evt ? period_q
                      : counter_q - COUNTER_W'(1);
    end

    to_d     = to_q;
    missed_d = missed_q;
    if (wr_status) begin
      to_d     = 1'b0;
      missed_d = '0;
    end
    if (evt) begin
      to_d = 1'b1;
      if (to_q && !wr_status && missed_q != MISSED_MAX)
        missed_d = missed_q + 8'd1;
    end

    run_d = run_q;
    if (stop || reload_q || (evt && !cont_q)) run_d = 1'b0;
    if (start) run_d = 1'b1;

    cont_d = cont_q;
    ito_d  = ito_q;
    if (wr_ctrl) begin
      cont_d = writedata[CTL_CONT];
      ito_d  = writedata[CTL_ITO];
    end

    snap_d = wr_snap ? counter_q : snap_q;

    prescale_d = prescale_q;
    if (wr_psc) prescale_d = writedata[PRESCALE_W-1:0];

    irq_d = to_d && ito_d;

    per_rd  = 32'(period_q);
    snap_rd = 32'(snap_q);
    psc_rd  = 32'(prescale_q);
    rd_d    = '0;
    unique case (address)
      ADDR_STATUS:   rd_d = {14'd0, run_q, to_q};
      ADDR_CONTROL:  rd_d = {14'd0, cont_q, ito_q};
      ADDR_PERIOD_L: rd_d = per_rd[15:0];
      ADDR_PERIOD_H: rd_d = per_rd[31:16];
      ADDR_SNAP_L:   rd_d = snap_rd[15:0];
      ADDR_SNAP_H:   rd_d = snap_rd[31:16];
      ADDR_PRESCALE: rd_d = psc_rd[15:0];
      ADDR_MISSED:   rd_d = {8'd0, missed_q};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_q  <= RST_P;
      period_q   <= RST_P;
      snap_q     <= '0;
      prescale_q <= '0;
      missed_q   <= '0;
      run_q      <= 1'b0;
      to_q       <= 1'b0;
      cont_q     <= 1'b0;
      ito_q      <= 1'b0;
      reload_q   <= 1'b0;
      rd_q       <= '0;
      irq_q      <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      period_q   <= period_d;
      snap_q     <= snap_d;
      prescale_q <= prescale_d;
      missed_q   <= missed_d;
      run_q      <= run_d;
      to_q       <= to_d;
      cont_q     <= cont_d;
      ito_q      <= ito_d;
      reload_q   <= reload_d;
      rd_q       <= rd_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = irq_q;

`ifdef MP3_TIMER_PULSE_OUT_EN
  logic pulse_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= evt;
    end
  end

  assign timeout_pulse = pulse_q;
`endif

endmodule

// File: tb/tb_mp3_interval_timer.sv
// Scoreboard bench for mp3_interval_timer.
// Bus ops queue expectations; a monitor pops and compares.
module tb_mp3_interval_timer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [15:0] writedata = '0;
  logic [15:0] readdata;
  logic        irq;
`ifdef MP3_TIMER_PULSE_OUT_EN
  logic        timeout_pulse;
`endif

  mp3_interval_timer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .write_n       (write_n),
    .writedata     (writedata),
    .readdata      (readdata),
    .irq           (irq)
`ifdef MP3_TIMER_PULSE_OUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } chk_t;

  chk_t        q[$];
  logic        req = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          pulse_cnt = 0;
  chk_t        mc;
  logic [15:0] act;

`ifdef MP3_TIMER_PULSE_OUT_EN
  always @(posedge clk)
    if (timeout_pulse) pulse_cnt = pulse_cnt + 1;
`endif

  always @(posedge clk) begin
    if (req) begin
      #1;
      checks = checks + 1;
      if (q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL scoreboard: monitor saw request, queue empty");
      end else begin
        mc = q.pop_front();
        case (mc.kind)
          0:       act = readdata;
          1:       act = {15'd0, irq};
          default: act = 16'(pulse_cnt);
        endcase
        if (act !== mc.exp) begin
          errors = errors + 1;
          $display("FAIL %s: got %h expected %h",
                   mc.name, act, mc.exp);
        end
      end
    end
  end

  task automatic rd(input logic [2:0] a, input logic [15:0] e,
                    input string n);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    q.push_back('{kind: 0, exp: e, name: n});
    req = 1'b1;
    @(posedge clk); #2;
    req = 1'b0; chipselect = 1'b0;
  endtask

  task automatic chk(input int k, input logic [15:0] e,
                     input string n);
    @(negedge clk);
    q.push_back('{kind: k, exp: e, name: n});
    req = 1'b1;
    @(posedge clk); #2;
    req = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d;
    chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #23;
    @(negedge clk);
    reset_n = 1'b1;

    // reset state
    rd(3'd0, 16'h0000, "rst_status");
    rd(3'd1, 16'h0000, "rst_control");
    rd(3'd2, 16'hF07F, "rst_period_l");
    rd(3'd3, 16'h02FA, "rst_period_h");
    rd(3'd4, 16'h0000, "rst_snap_l");
    rd(3'd5, 16'h0000, "rst_snap_h");
    rd(3'd6, 16'h0000, "rst_prescale");
    rd(3'd7, 16'h0000, "rst_missed");
    chk(1, 16'h0, "rst_irq");

    // START+STOP together runs; snapshot; period write stops
    wr(3'd1, 16'h000C);
    idle(1);
    wr(3'd4, 16'h0000);
    rd(3'd0, 16'h0002, "startstop_run");
    rd(3'd4, 16'hF07E, "snap_l_reset_period");
    rd(3'd5, 16'h02FA, "snap_h_reset_period");
    wr(3'd3, 16'h0000);
    idle(1);
    rd(3'd0, 16'h0000, "period_wr_stops");

    // continuous, period 4, prescale 0, ITO
    wr(3'd2, 16'h0004);
    idle(1);
    wr(3'd1, 16'h0007);
    idle(1);
    wr(3'd4, 16'h0000);
    rd(3'd4, 16'h0003, "snap_l_running");
    chk(1, 16'h0, "irq_before_1st");
    chk(1, 16'h1, "irq_1st_event");
    rd(3'd0, 16'h0003, "status_run_to");
    wr(3'd0, 16'h0000);
    chk(1, 16'h0, "irq_cleared");
    idle(1);
    chk(1, 16'h1, "irq_2nd_event");
    wr(3'd0, 16'h0000);
    rd(3'd7, 16'h0000, "missed_after_clr");
    chk(1, 16'h0, "irq_gap_a");
    chk(1, 16'h0, "irq_gap_b");
    chk(1, 16'h1, "irq_3rd_event");
    rd(3'd7, 16'h0000, "missed_still_0");
    idle(4);
    rd(3'd7, 16'h0001, "missed_one");
    rd(3'd1, 16'h0003, "control_read");
    wr(3'd1, 16'h0008);
    wr(3'd0, 16'h0000);

    // one-shot, period 9, prescale 3: event at 40 clk
    wr(3'd2, 16'h0009);
    idle(1);
    wr(3'd6, 16'h0003);
    pulse_cnt = 0;
    wr(3'd1, 16'h0004);
    idle(39);
    rd(3'd0, 16'h0002, "oneshot_pre_event");
    rd(3'd0, 16'h0001, "oneshot_event_stops");
    wr(3'd4, 16'h0000);
    rd(3'd4, 16'h0009, "oneshot_counter_reloaded");
    rd(3'd5, 16'h0000, "oneshot_snap_h");
    chk(1, 16'h0, "oneshot_irq_masked");
    idle(50);
    rd(3'd0, 16'h0001, "oneshot_no_restart");
    rd(3'd7, 16'h0000, "oneshot_no_2nd");
    rd(3'd6, 16'h0003, "prescale_read");
`ifdef MP3_TIMER_PULSE_OUT_EN
    chk(2, 16'h0001, "pulse_count");
`endif

    // continuous period 2, let MISSED saturate
    wr(3'd0, 16'h0000);
    wr(3'd6, 16'h0000);
    wr(3'd2, 16'h0002);
    idle(1);
    wr(3'd1, 16'h0006);
    idle(899);
    rd(3'd7, 16'h00FF, "missed_saturated");
    wr(3'd0, 16'h0000);
    rd(3'd7, 16'h0000, "missed_cleared");
    rd(3'd0, 16'h0002, "to_cleared");
    rd(3'd0, 16'h0003, "to_next_event");
    idle(1);
    wr(3'd0, 16'h0000);
    rd(3'd0, 16'h0003, "status_wr_on_event_to");
    rd(3'd7, 16'h0000, "status_wr_on_event_missed");

    // asynchronous reset mid-count
    idle(2);
    #1 reset_n = 1'b0;
    #12 reset_n = 1'b1;
    idle(1);
    rd(3'd0, 16'h0000, "rst2_status");
    rd(3'd2, 16'hF07F, "rst2_period_l");
    rd(3'd3, 16'h02FA, "rst2_period_h");
    rd(3'd7, 16'h0000, "rst2_missed");
    rd(3'd1, 16'h0000, "rst2_control");
    chk(1, 16'h0, "rst2_irq");

    idle(3);
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: %0d left, expected 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
